// File: rtl/mem_chk_pkg.sv
// Shared types and constants for the data-memory write checker.
package mem_chk_pkg;

  localparam int unsigned FC_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [FC_W-1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fail_code_t;

  // Index width that stays legal when the table has a single entry.
  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/exp_table.sv
// Expected (address, data) table: synchronous write and clear, combinational read.
module exp_table #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we_i && (32'(wr_idx_i) < DEPTH)) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_addr_o = '0;
    rd_data_o = '0;
    if (32'(rd_idx_i) < DEPTH) begin
      rd_addr_o = addr_q[rd_idx_i];
      rd_data_o = data_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors core data-memory writes against an ordered expected table and
// reports pass, mismatch or timeout together with the offending write.
module mem_write_checker
  import mem_chk_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter bit          STRICT      = 1'b1,
  localparam int unsigned IDX_W      = idx_width(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [CNT_W-1:0]  num_exp,
  input  logic              ign_en,
  input  logic [ADDR_W-1:0] ign_addr,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [FC_W-1:0]   fail_code,
  output logic [CNT_W-1:0]  match_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state_q, state_d;
  fail_code_t        fc_q, fc_d;
  logic [CNT_W-1:0]  mc_q, mc_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;

  logic [ADDR_W-1:0] tab_addr;
  logic [DATA_W-1:0] tab_data;
  logic              hit, ignored, timed_out;

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .clk_i     (clk),
    .rst_i     (reset),
    .we_i      (exp_we && (state_q != RUN)),
    .wr_idx_i  (exp_idx),
    .wr_addr_i (exp_addr),
    .wr_data_i (exp_data),
    .rd_idx_i  (IDX_W'(mc_q)),
    .rd_addr_o (tab_addr),
    .rd_data_o (tab_data)
  );

  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    mc_d      = mc_q;
    n_d       = n_q;
    to_d      = to_q;
    fa_d      = fa_q;
    fd_d      = fd_q;
    // Plain == so an X/Z on the bus never yields a match.
    hit       = (DataAdr == tab_addr) && (WriteData == tab_data);
    ignored   = ign_en && (DataAdr == ign_addr);
    timed_out = 1'b0;

    unique case (state_q)
      RUN: begin
        to_d      = (to_q == TO_W'(TIMEOUT_CYC)) ? to_q : to_q + 1'b1;
        timed_out = (to_d == TO_W'(TIMEOUT_CYC));
        if (MemWrite && !ignored && hit) begin
          mc_d = mc_q + 1'b1;
          if (mc_d == n_q) begin
            state_d = PASS;
          end else if (timed_out) begin
            state_d = FAIL;
            fc_d    = FC_TIMEOUT;
          end
        end else if (MemWrite && !ignored && STRICT) begin
          state_d = FAIL;
          fc_d    = FC_MISMATCH;
          fa_d    = DataAdr;
          fd_d    = WriteData;
        end else if (timed_out) begin
          state_d = FAIL;
          fc_d    = FC_TIMEOUT;
        end
      end
      IDLE, PASS, FAIL: begin
        if (start) begin
          n_d     = (32'(num_exp) > DEPTH) ? CNT_W'(DEPTH) : num_exp;
          mc_d    = '0;
          to_d    = '0;
          fc_d    = FC_NONE;
          fa_d    = '0;
          fd_d    = '0;
          state_d = (n_d == '0) ? PASS : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fc_q    <= FC_NONE;
      mc_q    <= '0;
      n_q     <= '0;
      to_q    <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      mc_q    <= mc_d;
      n_q     <= n_d;
      to_q    <= to_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  assign done        = (state_q == PASS) || (state_q == FAIL);
  assign pass        = (state_q == PASS);
  assign fail_code   = fc_q;
  assign match_count = mc_q;
  assign fail_addr   = fa_q;
  assign fail_data   = fd_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a strict and a lenient instance share stimulus
// and are compared each cycle against a queue-based model plus directed vectors.
module tb_mem_write_checker;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        reset, mem_write, exp_we, ign_en, start;
  logic [31:0] data_adr, write_data, exp_addr, exp_data, ign_addr;
  logic [1:0]  exp_idx;
  logic [2:0]  num_exp;

  logic        done_s, pass_s, done_l, pass_l;
  logic [1:0]  fc_s, fc_l;
  logic [2:0]  mc_s, mc_l;
  logic [31:0] fa_s, fd_s, fa_l, fd_l;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TO), .STRICT(1'b1)
  ) u_strict (
    .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr),
    .WriteData(write_data), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .num_exp(num_exp), .ign_en(ign_en), .ign_addr(ign_addr),
    .start(start), .done(done_s), .pass(pass_s), .fail_code(fc_s),
    .match_count(mc_s), .fail_addr(fa_s), .fail_data(fd_s)
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TO), .STRICT(1'b0)
  ) u_lenient (
    .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr),
    .WriteData(write_data), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .num_exp(num_exp), .ign_en(ign_en), .ign_addr(ign_addr),
    .start(start), .done(done_l), .pass(pass_l), .fail_code(fc_l),
    .match_count(mc_l), .fail_addr(fa_l), .fail_data(fd_l)
  );

  // Reference model: phase 0 idle, 1 running, 2 passed, 3 failed.
  // The outstanding expectations of a run are kept as a queue.
  int          m_ph  [2];
  int          m_n   [2];
  int          m_cyc [2];
  logic [31:0] m_ta  [2][DEPTH];
  logic [31:0] m_td  [2][DEPTH];
  logic [63:0] m_q   [2][$];
  logic [1:0]  m_fc  [2];
  logic [31:0] m_fa  [2];
  logic [31:0] m_fd  [2];

  task automatic model_fail(int s, logic [1:0] code, logic [31:0] a, logic [31:0] d);
    m_ph[s] = 3;
    m_fc[s] = code;
    m_fa[s] = a;
    m_fd[s] = d;
  endtask

  task automatic model_step(int s);
    bit strict;
    bit counted;
    strict = (s == 0);
    if (reset) begin
      m_ph[s] = 0; m_n[s] = 0; m_cyc[s] = 0;
      m_fc[s] = 0; m_fa[s] = 0; m_fd[s] = 0;
      m_q[s].delete();
      for (int i = 0; i < DEPTH; i++) begin
        m_ta[s][i] = 0;
        m_td[s][i] = 0;
      end
      return;
    end
    if (m_ph[s] == 1) begin
      m_cyc[s]++;
      counted = mem_write && !(ign_en && data_adr == ign_addr);
      if (counted && {data_adr, write_data} == m_q[s][0]) begin
        void'(m_q[s].pop_front());
        if (m_q[s].size() == 0) m_ph[s] = 2;
        else if (m_cyc[s] == TO) model_fail(s, 2'd2, 0, 0);
      end else if (counted && strict) begin
        model_fail(s, 2'd1, data_adr, write_data);
      end else if (m_cyc[s] == TO) begin
        model_fail(s, 2'd2, 0, 0);
      end
    end else begin
      if (exp_we) begin
        m_ta[s][exp_idx] = exp_addr;
        m_td[s][exp_idx] = exp_data;
      end
      if (start) begin
        m_n[s] = (int'(num_exp) > DEPTH) ? DEPTH : int'(num_exp);
        m_q[s].delete();
        for (int i = 0; i < m_n[s]; i++) m_q[s].push_back({m_ta[s][i], m_td[s][i]});
        m_cyc[s] = 0; m_fc[s] = 0; m_fa[s] = 0; m_fd[s] = 0;
        m_ph[s] = (m_n[s] == 0) ? 2 : 1;
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic get_out(int s, output logic d, output logic p, output logic [1:0] fc,
                         output logic [2:0] mc, output logic [31:0] fa, output logic [31:0] fd);
    if (s == 0) begin
      d = done_s; p = pass_s; fc = fc_s; mc = mc_s; fa = fa_s; fd = fd_s;
    end else begin
      d = done_l; p = pass_l; fc = fc_l; mc = mc_l; fa = fa_l; fd = fd_l;
    end
  endtask

  task automatic compare_model();
    for (int s = 0; s < 2; s++) begin
      logic d, p;
      logic [1:0] fc;
      logic [2:0] mc;
      logic [31:0] fa, fd;
      string pre;
      pre = (s == 0) ? "model.strict" : "model.lenient";
      get_out(s, d, p, fc, mc, fa, fd);
      chk({pre, ".done"}, d, m_ph[s] >= 2);
      chk({pre, ".pass"}, p, m_ph[s] == 2);
      chk({pre, ".fail_code"}, fc, m_fc[s]);
      chk({pre, ".match_count"}, mc, m_n[s] - m_q[s].size());
      chk({pre, ".fail_addr"}, fa, m_fa[s]);
      chk({pre, ".fail_data"}, fd, m_fd[s]);
    end
  endtask

  task automatic expect_out(string nm, int s, bit d, bit p, int fc, int mc,
                            logic [31:0] fa, logic [31:0] fd);
    logic ad, ap;
    logic [1:0] afc;
    logic [2:0] amc;
    logic [31:0] afa, afd;
    get_out(s, ad, ap, afc, amc, afa, afd);
    chk({nm, ".done"}, ad, d);
    chk({nm, ".pass"}, ap, p);
    chk({nm, ".fail_code"}, afc, fc);
    chk({nm, ".match_count"}, amc, mc);
    chk({nm, ".fail_addr"}, afa, fa);
    chk({nm, ".fail_data"}, afd, fd);
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge,
  // then single-cycle controls drop.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_model();
    reset = 0; start = 0; exp_we = 0; mem_write = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
  endtask

  task automatic load(int idx, logic [31:0] a, logic [31:0] d);
    exp_we = 1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
    tick();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    mem_write = 1; data_adr = a; write_data = d;
    tick();
  endtask

  task automatic go(int n);
    num_exp = 3'(n); start = 1;
    tick();
  endtask

  typedef struct {
    bit st;
    bit mw;
    logic [31:0] a;
    logic [31:0] d;
    bit e_done;
    bit e_pass;
    int e_fc;
    int e_mc;
    logic [31:0] e_fa;
    logic [31:0] e_fd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1; mem_write = 0; exp_we = 0; ign_en = 0; start = 0;
    data_adr = 0; write_data = 0; exp_addr = 0; exp_data = 0; ign_addr = 0;
    exp_idx = 0; num_exp = 0;
    @(negedge clk);
    do_reset();
    expect_out("reset.strict", 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset.lenient", 1, 0, 0, 0, 0, 0, 0);

    // Strict-instance vectors: basic pass, mismatch, restart after failure.
    vecs[0] = '{1, 0, 0,   0, 0, 0, 0, 0, 0,   0};
    vecs[1] = '{0, 1, 96,  3, 0, 0, 0, 0, 0,   0};
    vecs[2] = '{0, 1, 100, 7, 1, 1, 0, 1, 0,   0};
    vecs[3] = '{1, 0, 0,   0, 0, 0, 0, 0, 0,   0};
    vecs[4] = '{0, 1, 100, 8, 1, 0, 1, 0, 100, 8};
    vecs[5] = '{0, 1, 100, 7, 1, 0, 1, 0, 100, 8};
    vecs[6] = '{1, 0, 0,   0, 0, 0, 0, 0, 0,   0};
    vecs[7] = '{0, 1, 96,  7, 0, 0, 0, 0, 0,   0};
    vecs[8] = '{0, 1, 100, 7, 1, 1, 0, 1, 0,   0};
    load(0, 100, 7);
    num_exp = 1; ign_en = 1; ign_addr = 96;
    for (int i = 0; i < 9; i++) begin
      start = vecs[i].st; mem_write = vecs[i].mw;
      data_adr = vecs[i].a; write_data = vecs[i].d;
      tick();
      expect_out($sformatf("vec%0d", i), 0, vecs[i].e_done, vecs[i].e_pass,
                 vecs[i].e_fc, vecs[i].e_mc, vecs[i].e_fa, vecs[i].e_fd);
    end

    // Lenient sequence with stray writes; strict instance fails on the first one.
    do_reset();
    ign_en = 0;
    load(0, 100, 7); load(1, 104, 9); load(2, 108, 1);
    go(3);
    wr(200, 3);
    expect_out("lenseq.strict", 0, 1, 0, 1, 0, 200, 3);
    wr(100, 7); wr(300, 5); wr(104, 9);
    expect_out("lenseq.mid", 1, 0, 0, 0, 2, 0, 0);
    wr(108, 1);
    expect_out("lenseq.end", 1, 1, 1, 0, 3, 0, 0);

    // Timeout with no writes.
    do_reset();
    load(0, 100, 7);
    go(1);
    for (int i = 0; i < TO - 1; i++) tick();
    expect_out("timeout.before", 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("timeout.strict", 0, 1, 0, 2, 0, 0, 0);
    expect_out("timeout.lenient", 1, 1, 0, 2, 0, 0, 0);

    // Final match on the timeout edge wins.
    go(1);
    for (int i = 0; i < TO - 1; i++) tick();
    wr(100, 7);
    expect_out("prio.strict", 0, 1, 1, 0, 1, 0, 0);
    expect_out("prio.lenient", 1, 1, 1, 0, 1, 0, 0);

    // Reset mid-run clears status and table.
    load(1, 104, 9);
    go(2);
    wr(100, 7);
    expect_out("midrun.mc", 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    expect_out("midrun.reset", 0, 0, 0, 0, 0, 0, 0);
    go(1);
    wr(0, 0);
    expect_out("cleared.table", 0, 1, 1, 0, 1, 0, 0);
    go(0);
    expect_out("zero.strict", 0, 1, 1, 0, 0, 0, 0);
    expect_out("zero.lenient", 1, 1, 1, 0, 0, 0, 0);

    // Table writes during a run are dropped.
    load(0, 100, 7);
    go(1);
    exp_we = 1; exp_idx = 0; exp_addr = 500; exp_data = 5;
    tick();
    wr(100, 7);
    expect_out("we_in_run", 0, 1, 1, 0, 1, 0, 0);

    // num_exp above DEPTH clamps to DEPTH.
    load(1, 104, 9); load(2, 108, 1); load(3, 112, 2);
    go(7);
    wr(100, 7); wr(104, 9); wr(108, 1); wr(112, 2);
    expect_out("clamp", 0, 1, 1, 0, 4, 0, 0);

    // Randomised traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) reset = 1;
      else if (r < 14) begin
        start = 1;
        num_exp = 3'($urandom_range(0, 7));
      end else if (r < 26) begin
        exp_we = 1;
        exp_idx = 2'($urandom_range(0, 3));
        exp_addr = 4 * $urandom_range(0, 4);
        exp_data = $urandom_range(0, 3);
      end
      if (r % 17 == 0) begin
        ign_en = 1'($urandom_range(0, 1));
        ign_addr = 4 * $urandom_range(0, 4);
      end
      if ($urandom_range(0, 9) < 6) begin
        mem_write = 1;
        if ($urandom_range(0, 2) != 0) begin
          int k;
          k = (m_ph[1] == 1 && m_q[1].size() > 0) ? (m_n[1] - m_q[1].size())
                                                   : int'($urandom_range(0, 3));
          data_adr = m_ta[1][k];
          write_data = m_td[1][k];
        end else begin
          data_adr = 4 * $urandom_range(0, 4);
          write_data = $urandom_range(0, 3);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable self-checking monitor for processor data-memory write traffic; it replaces hard-coded single-address pass/fail benches.
- Sits beside `top`, tapping `MemWrite`, `DataAdr` and `WriteData`.
- Compares the write stream against a programmable ordered table of expected (address, data) pairs.
- Reports pass/fail, the failure cause, and the offending transaction.
- Supports a configurable ignore address, a strict/lenient mode and a cycle timeout.

Parameters:
- ADDR_W, 32, width of the write-address bus.
- DATA_W, 32, width of the write-data bus.
- DEPTH, 8, number of entries in the expected table (≥1).
- TIMEOUT_CYC, 1024, number of RUN cycles without completion before timeout failure (≥1).
- STRICT, 1, mode select: 1 = any non-ignored, non-matching write fails; 0 = non-matching writes are skipped.

Ports:
- clk, in, 1, system clock; everything samples on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- MemWrite, in, 1, write strobe from the core.
- DataAdr, in, ADDR_W, write address.
- WriteData, in, DATA_W, write data.
- exp_we, in, 1, table write enable; honoured only in IDLE/PASS/FAIL.
- exp_idx, in, $clog2(DEPTH), table entry index.
- exp_addr, in, ADDR_W, expected address to load.
- exp_data, in, DATA_W, expected data to load.
- num_exp, in, $clog2(DEPTH+1), number of table entries to check; values above DEPTH are clamped to DEPTH.
- ign_en, in, 1, enables the ignore-address filter.
- ign_addr, in, ADDR_W, address whose writes are always discarded.
- start, in, 1, one-cycle pulse that begins a check run.
- done, out, 1, high in PASS or FAIL.
- pass, out, 1, high in PASS only.
- fail_code, out, 2, 0 = NONE, 1 = MISMATCH, 2 = TIMEOUT.
- match_count, out, $clog2(DEPTH+1), number of entries matched so far.
- fail_addr, out, ADDR_W, address of the offending write.
- fail_data, out, DATA_W, data of the offending write.

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset (synchronous, wins over all other inputs):
  - state returns to IDLE;
  - done, pass, fail_code, match_count, fail_addr, fail_data and the timeout counter go to 0;
  - every table entry is cleared to 0.
- Reset asserted mid-RUN aborts the run the same edge; no status survives.
- Table load: exp_we at edge k writes entry exp_idx; the new value is usable for a start issued at edge k+1 or later. exp_we in RUN is ignored.
- start accepted in IDLE, PASS or FAIL. On the accepting edge:
  - latch n = min(num_exp, DEPTH);
  - clear match_count, the timeout counter, fail_* and pass;
  - enter RUN;
  - if n = 0, enter PASS instead.
- start in RUN is ignored.
- RUN, per rising edge with MemWrite = 1:
  - ign_en and DataAdr == ign_addr: write discarded; no state change.
  - DataAdr/WriteData equal to table[match_count]: match_count increments. When the new count equals n, go to PASS (pass = 1, done = 1).
  - Otherwise, STRICT = 1: go to FAIL, fail_code = MISMATCH, fail_addr/fail_data capture the write.
  - Otherwise, STRICT = 0: write skipped.
- Comparisons are exact on all ADDR_W and DATA_W bits. X/Z inputs must not produce a match; the bench treats them as a mismatch.
- Timeout:
  - The counter increments every RUN cycle, whether or not a write occurs, and saturates.
  - It reaches TIMEOUT_CYC on the TIMEOUT_CYC-th RUN edge. If completion has not occurred by then, go to FAIL with fail_code = TIMEOUT and fail_addr/fail_data = 0.
- Same-edge priority: completing match > mismatch > timeout. A final match on the timeout edge yields PASS.
- Status latency: a write sampled at edge k is reflected in the outputs immediately after edge k, with no extra pipeline stage.
- PASS and FAIL hold until start or reset. match_count freezes on exit from RUN.
- MemWrite outside RUN is ignored.

Decomposition:
- Package mem_chk_pkg:
  - state_t enum {IDLE, RUN, PASS, FAIL};
  - fail_code_t enum {FC_NONE = 0, FC_MISMATCH = 1, FC_TIMEOUT = 2};
  - localparam FC_W = 2.
- Sub-module exp_table:
  - DEPTH × (ADDR_W + DATA_W) register array;
  - synchronous write and synchronous reset clear;
  - combinational read port indexed by match_count.
- Top level holds the FSM, the timeout counter and the compare logic.

Test Plan:
- Basic pass: load entry 0 = (100, 7); num_exp = 1, ign_en = 1, ign_addr = 96; start; writes (96, 3), (100, 7) → after the second write, pass = 1, done = 1, match_count = 1, fail_code = 0.
- Strict mismatch (STRICT = 1): same table; write (100, 8) → FAIL, fail_code = 1, fail_addr = 100, fail_data = 8, match_count = 0.
- Lenient sequence (STRICT = 0, DEPTH = 4): table (100, 7), (104, 9), (108, 1); num_exp = 3; writes (200, 3), (100, 7), (300, 5), (104, 9), (108, 1) → PASS with match_count = 3.
- Timeout (TIMEOUT_CYC = 16): start with no writes → done rises after the 16th RUN edge, fail_code = 2, fail_addr = fail_data = 0.
- Same-edge priority (TIMEOUT_CYC = 16): final matching write on the 16th RUN edge → PASS, not TIMEOUT.
- Reset and boundaries: reset mid-RUN after 1 of 2 matches → IDLE with all outputs 0. Then start with num_exp = 0 → PASS on the next edge. exp_we during RUN leaves the table unchanged.
